regfile_bank_param: RTL and testbench
=====================================

// Module: regfile_bank_param
// PURPOSE
//  Parametrised register bank for the accelerator's register interface; one instance per register group.
//  Contains RW config registers, RO status registers and a write-only command register that emits one-cycle pulses.
//  Adds a sticky event register with write-1-to-clear, an interrupt mask and irq output.
//  Read data is registered with a valid strobe; byte-strobed writes and unmapped-address errors are supported.
// PARAMETERS
//  ADDR_W    14       address width
//  DATA_W    16       register width; must be a multiple of 8
//  NUM_RW    12       number of RW registers, at RW_BASE .. RW_BASE+NUM_RW-1
//  RW_BASE   'h001    first RW address
//  RW_RST    '0       reset values, NUM_RW*DATA_W flat; register i is at slice [i*DATA_W +: DATA_W]
//  NUM_RO    2        number of RO registers, at RO_BASE .. RO_BASE+NUM_RO-1
//  RO_BASE   'h040    first RO address
//  CMD_ADDR  'h080    command register address
//  CMD_W     10       command bits; must be <= DATA_W-1
//  EVT_ADDR  'h0C0    event status address; the mask register is at EVT_ADDR+1
//  EVT_W     8        event bits; must be <= DATA_W
// PORTS
//  clk         in   1               clock
//  rst         in   1               asynchronous, active-high reset
//  wr_en       in   1               write request, one cycle per access
//  rd_en       in   1               read request, one cycle per access
//  addr        in   ADDR_W          access address
//  write_data  in   DATA_W          write data
//  wr_strb     in   DATA_W/8        byte enables; apply to RW and mask registers only
//  read_data   out  DATA_W          registered read data
//  rd_valid    out  1               read_data valid, one-cycle pulse
//  addr_err    out  1               pulse: access to an unmapped address
//  rw_q        out  NUM_RW*DATA_W   RW register values driven to hardware
//  ro_d        in   NUM_RO*DATA_W   status values from hardware
//  cmd_pulse   out  CMD_W           command bits; one-cycle pulse per write
//  cmd_valid   out  1               high in the same cycle as cmd_pulse
//  evt_in      in   EVT_W           event set inputs, level sampled every cycle
//  irq         out  1               |(evt_q & mask_q)
// BEHAVIOUR
//  - Reset values:
//    - RW registers = RW_RST; evt_q = 0; mask_q = 0.
//    - read_data = 0; rd_valid, addr_err, cmd_pulse, cmd_valid, irq = 0.
//  - Writes:
//    - Take effect at the next rising edge.
//    - RW and mask registers update only the bytes whose wr_strb bit is set.
//    - Writes to RO addresses are ignored and raise no error.
//  - Read latency is 1 cycle:
//    - rd_en at edge N gives read_data and rd_valid at N+1.
//    - read_data holds its value until the next read.
//  - Read map:
//    - RW registers and the mask register return their stored values.
//    - RO addresses return ro_d, sampled at the rd_en edge.
//    - EVT_ADDR returns evt_q, zero-extended.
//    - CMD_ADDR returns 0.
//  - rd_en and wr_en to the same address in the same cycle: read returns the pre-write value.
//  - Unmapped address: reads return 0 with rd_valid=1; addr_err pulses for 1 cycle on a read or a write.
//  - Command: a write to CMD_ADDR registers write_data[CMD_W-1:0] into cmd_pulse and sets cmd_valid=1 for exactly 1 cycle.
//    - Back-to-back writes give back-to-back pulses.
//    - wr_strb is ignored for this address.
//  - Events, evaluated each edge: evt_q <= (evt_q & ~w1c) | evt_in.
//    - w1c = write_data[EVT_W-1:0] on a write to EVT_ADDR, otherwise 0.
//    - Set wins over clear in the same cycle.
//  - irq is combinational from flops only; it has no input-to-output path.
//  - Reset asserted mid-operation: all state returns to reset values immediately; an in-flight rd_valid is dropped.
//  - Address decode is exact compare on the full ADDR_W bits; overlapping parameter ranges are illegal.
// CONFIGURATION
//  - REGFILE_SHADOW_EN defined:
//    - Each RW register has a software copy and a hardware shadow; rw_q is driven from the shadow.
//    - A write to CMD_ADDR with write_data[DATA_W-1]=1 copies all software copies into the shadows at the following edge.
//    - That write counts as a command write, so cmd_valid also pulses.
//    - Reads return the software copy.
//    - Both copies reset to RW_RST.
//    - Software writes and the commit in the same cycle: the write lands first, so the commit copies the new value one edge later.
//  - REGFILE_SHADOW_EN undefined: no shadows; rw_q is the register itself; write_data[DATA_W-1] is ignored on CMD writes.
// TESTING
//  1. Reset, then read every RW address -> each returns RW_RST; reg 'hC with RW_RST='h8 -> read_data='h0008, rd_valid 1 cycle after rd_en.
//  2. Write 'hABCD to 'h002 with wr_strb=2'b01, then read -> 'h00CD; rw_q slice 1 = 'h00CD.
//  3. Write 'h0201 to CMD_ADDR -> cmd_pulse='h201 and cmd_valid=1 for exactly 1 cycle; read CMD_ADDR -> 0.
//  4. Pulse evt_in[3]; write mask='h08 -> irq=1.
//     - Write 'h08 to EVT_ADDR while evt_in[3]=1 -> bit stays set.
//     - Repeat with evt_in=0 -> evt_q=0 and irq=0 the next cycle.
//  5. Read 'h3FF and write 'h3FF -> addr_err pulses each time; read_data=0; no register changes.
//  6. SHADOW_EN: write 'h1234 to 'h003 -> rw_q is unchanged.
//     - Then write 'h8000 to CMD_ADDR -> rw_q slice 2 = 'h1234 one edge later.
//     - Assert rst mid-sequence -> all outputs return to reset values.

Source files
------------

// File: rtl/regfile_bank_param_if.sv
// Register-bank access bus: software-side request/response plus hardware-side register taps.
// master drives accesses and hardware inputs; slave is the register bank.
interface regfile_bank_param_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int NUM_RW = 12,
  parameter int NUM_RO = 2,
  parameter int CMD_W  = 10,
  parameter int EVT_W  = 8
);
  logic                     wr_en;
  logic                     rd_en;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        write_data;
  logic [DATA_W/8-1:0]      wr_strb;
  logic [DATA_W-1:0]        read_data;
  logic                     rd_valid;
  logic                     addr_err;
  logic [NUM_RW*DATA_W-1:0] rw_q;
  logic [NUM_RO*DATA_W-1:0] ro_d;
  logic [CMD_W-1:0]         cmd_pulse;
  logic                     cmd_valid;
  logic [EVT_W-1:0]         evt_in;
  logic                     irq;

  modport master (
    output wr_en, rd_en, addr, write_data, wr_strb, ro_d, evt_in,
    input  read_data, rd_valid, addr_err, rw_q, cmd_pulse, cmd_valid, irq
  );
  modport slave (
    input  wr_en, rd_en, addr, write_data, wr_strb, ro_d, evt_in,
    output read_data, rd_valid, addr_err, rw_q, cmd_pulse, cmd_valid, irq
  );
endinterface

// File: rtl/regfile_bank_param.sv
// Parametrised register bank: RW config, RO status, command pulses, sticky W1C events with irq mask.
// Optional REGFILE_SHADOW_EN: each RW register gets a hardware shadow committed by a CMD write with the MSB set.
module regfile_rw_cell #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                commit,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   sw_q,
  output logic [DATA_W-1:0]   hw_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sw_q <= RST_VAL;
    else if (we)
      for (int b = 0; b < DATA_W/8; b++)
        if (strb[b]) sw_q[b*8 +: 8] <= wdata[b*8 +: 8];

`ifdef REGFILE_SHADOW_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)         hw_q <= RST_VAL;
    else if (commit) hw_q <= sw_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign hw_q = sw_q;
`endif
endmodule

module regfile_bank_param #(
  parameter int                       ADDR_W   = 14,
  parameter int                       DATA_W   = 16,
  parameter int                       NUM_RW   = 12,
  parameter int                       RW_BASE  = 'h001,
  parameter logic [NUM_RW*DATA_W-1:0] RW_RST   = '0,
  parameter int                       NUM_RO   = 2,
  parameter int                       RO_BASE  = 'h040,
  parameter int                       CMD_ADDR = 'h080,
  parameter int                       CMD_W    = 10,
  parameter int                       EVT_ADDR = 'h0C0,
  parameter int                       EVT_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  regfile_bank_param_if.slave  bus
);
  localparam logic [ADDR_W-1:0] CMD_A = ADDR_W'(CMD_ADDR);
  localparam logic [ADDR_W-1:0] EVT_A = ADDR_W'(EVT_ADDR);
  localparam logic [ADDR_W-1:0] MSK_A = ADDR_W'(EVT_ADDR + 1);

  logic [NUM_RW-1:0]             rw_hit;
  logic [NUM_RO-1:0]             ro_hit;
  logic [NUM_RW-1:0][DATA_W-1:0] rw_sw, rw_hw;
  logic                          cmd_hit, evt_hit, msk_hit, mapped, cmd_wr, commit_q;
  logic [EVT_W-1:0]              evt_q, mask_q, w1c;
  logic [DATA_W-1:0]             rd_mux;
  logic [1:0]                    vld_pipe;

  assign cmd_hit = bus.addr == CMD_A;
  assign evt_hit = bus.addr == EVT_A;
  assign msk_hit = bus.addr == MSK_A;
  assign mapped  = (|rw_hit) | (|ro_hit) | cmd_hit | evt_hit | msk_hit;
  assign cmd_wr  = bus.wr_en & cmd_hit;
  assign w1c     = (bus.wr_en & evt_hit) ? bus.write_data[EVT_W-1:0] : '0;

  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    assign rw_hit[i] = bus.addr == ADDR_W'(RW_BASE + i);
    regfile_rw_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL (RW_RST[i*DATA_W +: DATA_W])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .we     (bus.wr_en & rw_hit[i]),
      .commit (commit_q),
      .strb   (bus.wr_strb),
      .wdata  (bus.write_data),
      .sw_q   (rw_sw[i]),
      .hw_q   (rw_hw[i])
    );
  end

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
    assign ro_hit[i] = bus.addr == ADDR_W'(RO_BASE + i);
  end

  assign bus.rw_q = rw_hw;

`ifdef REGFILE_SHADOW_EN
  // Commit is delayed one edge so a software write in the commit cycle is captured.
  always_ff @(posedge clk or posedge rst)
    if (rst) commit_q <= 1'b0;
    else     commit_q <= cmd_wr & bus.write_data[DATA_W-1];
`else
  assign commit_q = 1'b0;
`endif

  // Read mux sees flop outputs only, so a same-cycle write returns the old value.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_RW; i++) if (rw_hit[i]) rd_mux = rw_sw[i];
    for (int i = 0; i < NUM_RO; i++) if (ro_hit[i]) rd_mux = bus.ro_d[i*DATA_W +: DATA_W];
    if (evt_hit) rd_mux = DATA_W'(evt_q);
    if (msk_hit) rd_mux = DATA_W'(mask_q);
  end

  assign vld_pipe[0]  = bus.rd_en;
  assign bus.rd_valid = vld_pipe[1];
  assign bus.irq      = |(evt_q & mask_q);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe[1]   <= 1'b0;
      bus.read_data <= '0;
      bus.addr_err  <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_pulse <= '0;
      evt_q         <= '0;
      mask_q        <= '0;
    end else begin
      vld_pipe[1]   <= vld_pipe[0];
      if (bus.rd_en) bus.read_data <= rd_mux;
      bus.addr_err  <= (bus.wr_en | bus.rd_en) & ~mapped;
      bus.cmd_valid <= cmd_wr;
      bus.cmd_pulse <= cmd_wr ? bus.write_data[CMD_W-1:0] : '0;
      evt_q         <= (evt_q & ~w1c) | bus.evt_in;
      if (bus.wr_en & msk_hit)
        for (int b = 0; b < EVT_W; b++)
          if (bus.wr_strb[b/8]) mask_q[b] <= bus.write_data[b];
    end
endmodule

// File: tb/tb_regfile_bank_param.sv
// Scoreboard bench for regfile_bank_param: random + directed accesses against a register-map model.
module tb_regfile_bank_param;
  localparam logic [191:0] RST_V = 192'h8 << 176;
  localparam logic [13:0]  CMD_A = 14'h080, EVT_A = 14'h0C0, MSK_A = 14'h0C1;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  regfile_bank_param_if bus ();
  regfile_bank_param #(.RW_RST(RST_V)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit           rd_valid;
    logic [15:0]  rdata;
    bit           addr_err;
    bit           cmd_valid;
    logic [9:0]   cmd_pulse;
    bit           irq;
    logic [191:0] rw_q;
  } exp_t;

  exp_t        cyc_q[$];
  logic [15:0] rd_q[$];
  int          n_chk = 0, n_pass = 0;

  logic [15:0] m_sw[12], m_sh[12];
  logic [7:0]  m_evt, m_mask;
  logic [15:0] m_rdata;
  bit          m_commit;

  function automatic void chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void fail_now(input string nm, input int got, input int want);
    n_chk++;
    $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
  endfunction

  function automatic bit is_mapped(input logic [13:0] a);
    return (a >= 14'd1 && a <= 14'd12) || a == 14'h40 || a == 14'h41 ||
           a == CMD_A || a == EVT_A || a == MSK_A;
  endfunction

  function automatic logic [15:0] read_val(input logic [13:0] a, input logic [31:0] ro);
    if (a >= 14'd1 && a <= 14'd12) return m_sw[a - 14'd1];
    if (a == 14'h40) return ro[15:0];
    if (a == 14'h41) return ro[31:16];
    if (a == EVT_A)  return {8'h0, m_evt};
    if (a == MSK_A)  return {8'h0, m_mask};
    return 16'h0;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e.rd_valid = 0; e.rdata = 16'h0; e.addr_err = 0; e.cmd_valid = 0;
    e.cmd_pulse = 10'h0; e.irq = 0; e.rw_q = RST_V;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_sw[i] = RST_V[i*16 +: 16];
      m_sh[i] = RST_V[i*16 +: 16];
    end
    m_evt = 8'h0; m_mask = 8'h0; m_rdata = 16'h0; m_commit = 0;
    rd_q.delete();
  endtask

  // Effect of one rising edge on the register map; pushes what the outputs must show afterwards.
  task automatic model_edge(input bit we, input bit re, input logic [13:0] a, input logic [15:0] wd,
                            input logic [1:0] st, input logic [31:0] ro, input logic [7:0] ev);
    exp_t e;
    logic [7:0] w1c;
    e.rd_valid = re;
    if (re) begin
      m_rdata = read_val(a, ro);
      rd_q.push_back(m_rdata);
    end
    e.rdata     = m_rdata;
    e.addr_err  = (we || re) && !is_mapped(a);
    e.cmd_valid = we && a == CMD_A;
    e.cmd_pulse = e.cmd_valid ? wd[9:0] : 10'h0;
`ifdef REGFILE_SHADOW_EN
    if (m_commit) for (int i = 0; i < 12; i++) m_sh[i] = m_sw[i];
    m_commit = e.cmd_valid && wd[15];
`endif
    if (we && a >= 14'd1 && a <= 14'd12) begin
      if (st[0]) m_sw[a - 14'd1][7:0]  = wd[7:0];
      if (st[1]) m_sw[a - 14'd1][15:8] = wd[15:8];
    end
    if (we && a == MSK_A && st[0]) m_mask = wd[7:0];
    w1c   = (we && a == EVT_A) ? wd[7:0] : 8'h0;
    m_evt = (m_evt & ~w1c) | ev;
    e.irq = |(m_evt & m_mask);
    for (int i = 0; i < 12; i++) begin
`ifdef REGFILE_SHADOW_EN
      e.rw_q[i*16 +: 16] = m_sh[i];
`else
      e.rw_q[i*16 +: 16] = m_sw[i];
`endif
    end
    cyc_q.push_back(e);
  endtask

  // Called just after a falling edge; drives one access for the next rising edge.
  task automatic op(input bit we, input bit re, input logic [13:0] a, input logic [15:0] wd,
                    input logic [1:0] st, input logic [7:0] ev);
    logic [31:0] ro;
    ro = $urandom;
    bus.wr_en = we; bus.rd_en = re; bus.addr = a; bus.write_data = wd;
    bus.wr_strb = st; bus.ro_d = ro; bus.evt_in = ev;
    model_edge(we, re, a, wd, st, ro, ev);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.rd_en = 0; bus.addr = '0; bus.write_data = '0;
    bus.wr_strb = '0; bus.ro_d = '0; bus.evt_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_rd_valid",  bus.rd_valid,  0);
    chk("rst_read_data", bus.read_data, 0);
    chk("rst_addr_err",  bus.addr_err,  0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_pulse", bus.cmd_pulse, 0);
    chk("rst_irq",       bus.irq,       0);
    chk("rst_rw_q",      bus.rw_q,      RST_V);
    cyc_q.push_back(reset_rec());
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [13:0] pick_addr();
    logic [13:0] um[9];
    um = '{14'h0, 14'hD, 14'h3F, 14'h42, 14'h7F, 14'h81, 14'hC2, 14'h3FF, 14'h3FFF};
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 14'(1 + $urandom_range(0, 11));
      4:          return 14'h40 + 14'($urandom_range(0, 1));
      5:          return CMD_A;
      6:          return EVT_A;
      7:          return MSK_A;
      default:    return um[$urandom_range(0, 8)];
    endcase
  endfunction

  // Monitor: compares every cycle that has an expectation, and pops read data on rd_valid.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("rd_valid",  bus.rd_valid,  e.rd_valid);
        chk("read_hold", bus.read_data, e.rdata);
        chk("addr_err",  bus.addr_err,  e.addr_err);
        chk("cmd_valid", bus.cmd_valid, e.cmd_valid);
        chk("cmd_pulse", bus.cmd_pulse, e.cmd_pulse);
        chk("irq",       bus.irq,       e.irq);
        chk("rw_q",      bus.rw_q,      e.rw_q);
        if (bus.rd_valid === 1'b1) begin
          if (rd_q.size() == 0) fail_now("rd_unexpected", 1, 0);
          else chk("rd_data", bus.read_data, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    for (int i = 1; i <= 12; i++) op(0, 1, 14'(i), 16'h0, 2'b00, 8'h0);
    op(0, 0, 14'h0, 16'h0, 2'b00, 8'h0);

    op(1, 0, 14'h002, 16'hABCD, 2'b01, 8'h0);
    op(0, 1, 14'h002, 16'h0, 2'b00, 8'h0);
    op(1, 1, 14'h002, 16'h5A5A, 2'b11, 8'h0);
    op(0, 1, 14'h002, 16'h0, 2'b00, 8'h0);

    op(1, 0, CMD_A, 16'h0201, 2'b00, 8'h0);
    op(1, 0, CMD_A, 16'h03FF, 2'b11, 8'h0);
    op(0, 0, 14'h0, 16'h0, 2'b00, 8'h0);
    op(0, 1, CMD_A, 16'h0, 2'b00, 8'h0);

    op(0, 0, 14'h0, 16'h0, 2'b00, 8'h08);
    op(1, 0, MSK_A, 16'h0008, 2'b11, 8'h0);
    op(0, 1, EVT_A, 16'h0, 2'b00, 8'h0);
    op(1, 0, EVT_A, 16'h0008, 2'b00, 8'h08);
    op(1, 0, EVT_A, 16'h0008, 2'b00, 8'h0);
    op(0, 1, EVT_A, 16'h0, 2'b00, 8'h0);

    op(0, 1, 14'h3FF, 16'h0, 2'b00, 8'h0);
    op(1, 0, 14'h3FF, 16'hFFFF, 2'b11, 8'h0);
    op(1, 0, 14'h040, 16'hFFFF, 2'b11, 8'h0);
    op(0, 1, 14'h3FF, 16'h0, 2'b00, 8'h0);

    op(1, 0, 14'h003, 16'h1234, 2'b11, 8'h0);
    op(0, 0, 14'h0, 16'h0, 2'b00, 8'h0);
    op(1, 0, CMD_A, 16'h8000, 2'b00, 8'h0);
    op(1, 0, 14'h003, 16'h4321, 2'b11, 8'h0);
    op(0, 0, 14'h0, 16'h0, 2'b00, 8'h0);
    op(0, 1, 14'h003, 16'h0, 2'b00, 8'h0);
    do_reset();

    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) begin
        op(0, 1, 14'h001, 16'h0, 2'b00, 8'h0);
        do_reset();
      end else begin
        op(1'($urandom), 1'($urandom), pick_addr(), 16'($urandom), 2'($urandom),
           ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0);
      end
    end

    for (int i = 0; i < 3; i++) op(0, 0, 14'h0, 16'h0, 2'b00, 8'h0);
    for (int i = 0; i < 10 && cyc_q.size() > 0; i++) @(negedge clk);
    if (cyc_q.size() != 0) fail_now("cyc_q_drain", cyc_q.size(), 0);
    if (rd_q.size() != 0)  fail_now("rd_q_drain", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
